// File: rtl/snake_pkg.sv
// snake_pkg: shared encodings and helpers for the snake movement engine
package snake_pkg;
  typedef enum logic [1:0] {RUNNING = 2'b00, DIE = 2'b01, INITIAL = 2'b10} game_state_e;
  typedef enum logic [1:0] {UP = 2'd0, DOWN = 2'd1, LEFT = 2'd2, RIGHT = 2'd3} dir_e;
  localparam int GRID_W_DEF = 40;
  localparam int GRID_H_DEF = 30;
  // UP/DOWN and LEFT/RIGHT differ only in bit 0
  function automatic dir_e opposite(dir_e d);
    return dir_e'(d ^ 2'b01);
  endfunction
endpackage

// File: rtl/snake_tick_gen.sv
// snake_tick_gen: movement tick divider, step strobe on terminal count
module snake_tick_gen #(
  parameter int MOVE_DIV = 25_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic step
);
  localparam int W = MOVE_DIV > 1 ? $clog2(MOVE_DIV) : 1;
  logic [W-1:0] cnt;
  assign step = en && cnt == W'(MOVE_DIV - 1);
  always_ff @(posedge clk) begin
    if (rst || clr) cnt <= '0;
    else if (en) cnt <= step ? '0 : cnt + W'(1);
  end
endmodule

// File: rtl/snake_body_engine.sv
// snake_body_engine: snake movement, growth, collision flags and per-cell occupancy query
module snake_body_engine import snake_pkg::*; #(
  parameter int GRID_W    = GRID_W_DEF,
  parameter int GRID_H    = GRID_H_DEF,
  parameter int CW        = 6,
  parameter int MAX_LEN   = 32,
  parameter int START_LEN = 3,
  parameter int START_X   = 20,
  parameter int START_Y   = 15,
  parameter int MOVE_DIV  = 25_000_000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    game_state,
  input  logic          up,
  input  logic          down,
  input  logic          left,
  input  logic          right,
  input  logic [CW-1:0] food_x,
  input  logic [CW-1:0] food_y,
  input  logic          food_valid,
  output logic          hit_boundary,
  output logic          hit_self,
  output logic          eat,
  output logic [5:0]    len,
  output logic [CW-1:0] head_x,
  output logic [CW-1:0] head_y,
  input  logic [CW-1:0] qry_x,
  input  logic [CW-1:0] qry_y,
  output logic          qry_head,
  output logic          qry_body
);
  localparam logic signed [CW:0] GW = (CW+1)'(GRID_W);
  localparam logic signed [CW:0] GH = (CW+1)'(GRID_H);
  logic [CW-1:0] seg_x [MAX_LEN];
  logic [CW-1:0] seg_y [MAX_LEN];
  dir_e dir, pend_dir, req;
  logic init, step, bnd, grow, self_hit;
  logic signed [CW:0] nx, ny;
  logic [MAX_LEN-1:0] self_v, body_v;
  assign init = game_state == INITIAL;
  assign head_x = seg_x[0];
  assign head_y = seg_y[0];
  snake_tick_gen #(.MOVE_DIV(MOVE_DIV)) u_tick (
    .clk(clk), .rst(rst), .clr(init), .en(game_state == RUNNING), .step(step)
  );
  assign req = up ? UP : down ? DOWN : left ? LEFT : RIGHT;
  // one extra sign bit so stepping off the 0 edge reads as negative instead of wrapping
  assign nx = $signed({1'b0, seg_x[0]}) + $signed(pend_dir == RIGHT ? (CW+1)'(1) : pend_dir == LEFT ? '1 : '0);
  assign ny = $signed({1'b0, seg_y[0]}) + $signed(pend_dir == DOWN ? (CW+1)'(1) : pend_dir == UP ? '1 : '0);
  assign bnd = nx[CW] || nx >= GW || ny[CW] || ny >= GH;
  assign grow = food_valid && nx[CW-1:0] == food_x && ny[CW-1:0] == food_y && !bnd;
  assign self_hit = |self_v;
  for (genvar k = 0; k < MAX_LEN; k++) begin : g_cmp
    // the tail only blocks the move when growth keeps it in place
    assign self_v[k] = seg_x[k] == nx[CW-1:0] && seg_y[k] == ny[CW-1:0] &&
                       (6'(k + 1) < len || (6'(k + 1) == len && grow));
    assign body_v[k] = k != 0 && 6'(k) < len && seg_x[k] == qry_x && seg_y[k] == qry_y;
  end
  always_ff @(posedge clk) begin
    if (rst || init) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x[i] <= CW'(START_X - i);
        seg_y[i] <= CW'(START_Y);
      end
      len <= 6'(START_LEN);
      dir <= RIGHT;
      pend_dir <= RIGHT;
      hit_boundary <= 1'b0;
      hit_self <= 1'b0;
      eat <= 1'b0;
    end else begin
      eat <= 1'b0;
      if ((up || down || left || right) && req != opposite(dir)) pend_dir <= req;
      if (step) begin
        dir <= pend_dir;
        hit_boundary <= hit_boundary | bnd;
        hit_self <= hit_self | self_hit;
        if (!bnd && !self_hit) begin
          seg_x[0] <= nx[CW-1:0];
          seg_y[0] <= ny[CW-1:0];
          for (int i = 1; i < MAX_LEN; i++) begin
            seg_x[i] <= seg_x[i-1];
            seg_y[i] <= seg_y[i-1];
          end
          eat <= grow;
          if (grow && len < 6'(MAX_LEN)) len <= len + 6'd1;
        end
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      qry_head <= 1'b0;
      qry_body <= 1'b0;
    end else begin
      qry_head <= seg_x[0] == qry_x && seg_y[0] == qry_y;
      qry_body <= |body_v;
    end
  end
endmodule

// File: tb/tb_snake_body_engine.sv
// tb_snake_body_engine: directed scenarios plus random play checked against a queue-based snake model
module tb_snake_body_engine;
  localparam int MD = 4, GW = 40, GH = 30, ML = 32;
  logic clk = 1'b0, rst = 1'b1;
  logic [1:0] gs = 2'b10;
  logic up = 0, down = 0, left = 0, right = 0, fv = 0;
  logic [5:0] fx = 0, fy = 0, qx = 0, qy = 0;
  logic hb, hs, eat, qh, qb;
  logic [5:0] len, hx, hy;
  int nchk = 0, nbad = 0;
  int bx[$], by[$];
  int mdir, mpend, mcnt;
  bit mhb, mhs, meat, mqh, mqb;
  int dxv[4] = '{0, 0, -1, 1};
  int dyv[4] = '{-1, 1, 0, 0};

  snake_body_engine #(.MOVE_DIV(MD)) dut (
    .clk(clk), .rst(rst), .game_state(gs), .up(up), .down(down), .left(left), .right(right),
    .food_x(fx), .food_y(fy), .food_valid(fv), .hit_boundary(hb), .hit_self(hs), .eat(eat),
    .len(len), .head_x(hx), .head_y(hy), .qry_x(qx), .qry_y(qy), .qry_head(qh), .qry_body(qb)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    bx = {}; by = {};
    for (int i = 0; i < 3; i++) begin bx.push_back(20 - i); by.push_back(15); end
    mdir = 3; mpend = 3; mcnt = 0; mhb = 0; mhs = 0; meat = 0;
  endtask

  task automatic model_step(input int d);
    int nx, ny, n;
    bit bnd, grow, self;
    nx = bx[0] + dxv[d]; ny = by[0] + dyv[d]; n = bx.size();
    bnd = nx < 0 || nx >= GW || ny < 0 || ny >= GH;
    grow = fv && nx == int'(fx) && ny == int'(fy) && !bnd;
    self = 0;
    for (int k = 0; k < n; k++)
      if (bx[k] == nx && by[k] == ny && (k < n - 1 || grow)) self = 1;
    mdir = d; mhb |= bnd; mhs |= self;
    if (!bnd && !self) begin
      bx.push_front(nx); by.push_front(ny);
      if (!(grow && n < ML)) begin void'(bx.pop_back()); void'(by.pop_back()); end
      meat = grow;
    end
  endtask

  task automatic model_edge();
    bit h, b;
    int op, rq;
    h = int'(qx) == bx[0] && int'(qy) == by[0];
    b = 0;
    for (int i = 1; i < bx.size(); i++) if (int'(qx) == bx[i] && int'(qy) == by[i]) b = 1;
    if (rst) begin mqh = 0; mqb = 0; model_reset(); return; end
    mqh = h; mqb = b; meat = 0;
    if (gs == 2'b10) begin model_reset(); return; end
    op = mpend;
    if (up || down || left || right) begin
      rq = up ? 0 : down ? 1 : left ? 2 : 3;
      if (rq != (mdir ^ 1)) mpend = rq;
    end
    if (gs == 2'b00) begin
      if (mcnt == MD - 1) begin mcnt = 0; model_step(op); end
      else mcnt++;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    check("head_x", hx, bx[0]);
    check("head_y", hy, by[0]);
    check("len", len, bx.size());
    check("eat", eat, meat);
    check("hit_boundary", hb, mhb);
    check("hit_self", hs, mhs);
    check("qry_head", qh, mqh);
    check("qry_body", qb, mqb);
  endtask

  task automatic ticks(input int n);
    repeat (n * MD) cyc();
  endtask

  initial begin
    int sat, dwell, k;
    cyc();
    rst = 0;
    cyc();
    check("init_len", len, 3);
    check("init_head_x", hx, 20);
    qx = 19; qy = 15; cyc();
    check("q19_body", qb, 1); check("q19_head", qh, 0);
    qx = 20; cyc();
    check("q20_head", qh, 1);
    qx = 17; cyc();
    check("q17_body", qb, 0); check("q17_head", qh, 0);
    // straight run, then food directly ahead
    gs = 2'b00;
    ticks(1); check("t1_head", hx, 21);
    ticks(1); check("t2_head", hx, 22);
    left = 1; cyc(); left = 0; ticks(1); check("rev_ignored", hx, 23);
    fv = 1; fx = 24; fy = 15;
    repeat (MD - 1) cyc();
    check("eat_pulse", eat, 1); check("eat_len", len, 4);
    cyc(); check("eat_once", eat, 0);
    fv = 0;
    // up then left inside one tick: left is rejected against the moved direction
    gs = 2'b10; cyc(); gs = 2'b00;
    up = 1; cyc(); up = 0; left = 1; cyc(); left = 0;
    repeat (MD - 2) cyc();
    check("turn_up_x", hx, 20); check("turn_up_y", hy, 14);
    // grow to 5 then curl into the body
    gs = 2'b10; cyc(); gs = 2'b00;
    fv = 1; fx = 21; fy = 15; ticks(1);
    fx = 22; ticks(1); fv = 0;
    up = 1; ticks(1); up = 0;
    left = 1; ticks(1); left = 0;
    down = 1; ticks(1); down = 0;
    check("self_flag", hs, 1); check("self_hold_x", hx, 21); check("self_hold_y", hy, 14);
    gs = 2'b01; repeat (3) cyc();
    check("self_sticky", hs, 1);
    // boundary: run right into x=39 wall
    gs = 2'b10; cyc(); gs = 2'b00;
    k = 0;
    while (!mhb && k < 200) begin cyc(); k++; end
    check("bnd_reached", k < 200, 1);
    check("bnd_flag", hb, 1); check("bnd_hold_x", hx, 39);
    gs = 2'b01; repeat (5) cyc();
    check("bnd_sticky", hb, 1);
    gs = 2'b10; cyc();
    check("bnd_clear", hb, 0); check("bnd_reset_x", hx, 20);
    // zigzag feeding until length saturates
    gs = 2'b00; sat = 0; k = 0;
    while (sat < 3 && k < 1000) begin
      up = 0; down = 0; left = 0; right = 0;
      if (mdir == 3 && bx[0] >= 37) up = 1;
      else if (mdir == 2 && bx[0] <= 3) up = 1;
      else if (mdir == 0) begin if (bx[0] >= 37) left = 1; else right = 1; end
      fv = 1; fx = 6'(bx[0] + dxv[mpend]); fy = 6'(by[0] + dyv[mpend]);
      qx = 6'(bx[bx.size() - 1]); qy = 6'(by[by.size() - 1]);
      cyc(); k++;
      if (meat && bx.size() == ML) sat++;
    end
    check("sat_reached", sat, 3);
    check("sat_len", len, ML);
    up = 0; down = 0; left = 0; right = 0; fv = 0;
    gs = 2'b01; repeat (3) cyc();
    gs = 2'b10; cyc();
    // random play with a simple game FSM around the engine
    gs = 2'b00; dwell = 0;
    for (int c = 0; c < 4000; c++) begin
      up = $urandom_range(0, 7) == 0; down = $urandom_range(0, 7) == 0;
      left = $urandom_range(0, 7) == 0; right = $urandom_range(0, 7) == 0;
      fv = $urandom_range(0, 1);
      if ($urandom_range(0, 1)) begin fx = 6'(bx[0] + dxv[mpend]); fy = 6'(by[0] + dyv[mpend]); end
      else begin fx = 6'($urandom_range(0, GW - 1)); fy = 6'($urandom_range(0, GH - 1)); end
      if ($urandom_range(0, 1)) begin
        int i = $urandom_range(0, bx.size() - 1);
        qx = 6'(bx[i]); qy = 6'(by[i]);
      end else begin qx = 6'($urandom_range(0, 63)); qy = 6'($urandom_range(0, 63)); end
      rst = $urandom_range(0, 499) == 0;
      if (gs == 2'b00 && (mhb || mhs)) begin gs = 2'b01; dwell = $urandom_range(3, 8); end
      else if (gs == 2'b01) begin if (dwell == 0) gs = 2'b10; else dwell--; end
      else if (gs == 2'b10) gs = 2'b00;
      cyc();
    end
    rst = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nbad);
    $finish;
  end
endmodule
